// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : 2-in / 2-out ring buffer between the I-cache and decode.
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
  parameter  int DEPTH = 16,
  parameter  int IW    = 32,
  parameter  int PW    = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            stall,
  input  logic            in_valid,
  input  logic            in_two,
  input  logic [PW-1:0]   in_pc,
  input  logic [2*IW-1:0] in_ir,
  output logic            in_ready,
  output logic            out_valid0,
  output logic            out_valid1,
  output logic [IW-1:0]   out_ir0,
  output logic [PW-1:0]   out_pc0,
  output logic [IW-1:0]   out_ir1,
  output logic [PW-1:0]   out_pc1,
  input  logic [1:0]      out_pop,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] mem_ir [DEPTH];
  logic [PW-1:0] mem_pc [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr1;
  logic [AW-1:0] wr_ptr1;
  logic          push;
  logic [1:0]    push_n;
  logic [1:0]    pop_sat;
  logic [1:0]    eff_pop;

  assign rd_ptr1 = rd_ptr + AW'(1);
  assign wr_ptr1 = wr_ptr + AW'(1);

  // Ready only when a full two-wide packet fits, so fetch never has to split one.
  assign in_ready = (count <= CW'(DEPTH - 2));
  assign push     = in_valid & in_ready & ~stall & ~flush;

  always_comb begin
    push_n = 2'd0;
    if (push) begin
      push_n = in_two ? 2'd2 : 2'd1;
    end
  end

  // Over-pop is clamped to the current occupancy instead of underflowing.
  assign pop_sat = (out_pop == 2'd3) ? 2'd2 : out_pop;
  assign eff_pop = (CW'(pop_sat) > count) ? count[1:0] : pop_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (!stall) begin
      rd_ptr <= rd_ptr + AW'(eff_pop);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + CW'(push_n) - CW'(eff_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir[wr_ptr] <= in_ir[IW-1:0];
      mem_pc[wr_ptr] <= in_pc;
      if (in_two) begin
        mem_ir[wr_ptr1] <= in_ir[2*IW-1:IW];
        mem_pc[wr_ptr1] <= in_pc + PW'(4);
      end
    end
  end

  assign out_valid0 = (count != '0);
  assign out_valid1 = (count >= CW'(2));
  assign out_ir0    = out_valid0 ? mem_ir[rd_ptr]  : '0;
  assign out_pc0    = out_valid0 ? mem_pc[rd_ptr]  : '0;
  assign out_ir1    = out_valid1 ? mem_ir[rd_ptr1] : '0;
  assign out_pc1    = out_valid1 ? mem_pc[rd_ptr1] : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed self-checking bench for fetch_queue (DEPTH=16).
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_two;
  logic [31:0] in_pc;
  logic [63:0] in_ir;
  logic        in_ready;
  logic        out_valid0;
  logic        out_valid1;
  logic [31:0] out_ir0;
  logic [31:0] out_pc0;
  logic [31:0] out_ir1;
  logic [31:0] out_pc1;
  logic [1:0]  out_pop;
  logic [4:0]  count;

  int passed;
  int total;
  int seq;
  int head;
  logic [31:0] base;

  fetch_queue #(.DEPTH(16), .IW(32), .PW(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_two(in_two), .in_pc(in_pc), .in_ir(in_ir),
    .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_ir0(out_ir0), .out_pc0(out_pc0), .out_ir1(out_ir1), .out_pc1(out_pc1),
    .out_pop(out_pop), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_two   = 1'b0;
    out_pop  = 2'd0;
    flush    = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_two = 1'b1; in_pc = 32'h40; in_ir = {32'd1, 32'd0}; tick;
    in_pc = 32'h48; in_ir = {32'd3, 32'd2}; tick;
    in_two = 1'b0; in_pc = 32'h50; in_ir = {32'd0, 32'd4}; tick;
    idle;
    total++; if (count !== 5'd5) $display("FAIL rst_pre_count got %0d want 5", count); else passed++;
    #1 rstn = 1'b0;
    #1;
    total++; if (count !== 5'd0) $display("FAIL rst_count got %0d want 0", count); else passed++;
    total++; if ({out_valid0, out_valid1} !== 2'b00) $display("FAIL rst_valid got %b want 00", {out_valid0, out_valid1}); else passed++;
    total++; if ({out_ir0, out_pc0, out_ir1, out_pc1} !== 128'd0) $display("FAIL rst_data got %h want 0", {out_ir0, out_pc0, out_ir1, out_pc1}); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready); else passed++;
    @(posedge clk);
    #1 rstn = 1'b1;
    tick;
  endtask

  task automatic test_two_push;
    in_valid = 1'b1; in_two = 1'b1; in_pc = 32'h1c000000; in_ir = {32'hBBBB, 32'hAAAA};
    #1;
    total++; if (out_valid0 !== 1'b0) $display("FAIL nobypass_valid0 got %b want 0", out_valid0); else passed++;
    tick;
    idle;
    total++; if (out_pc0 !== 32'h1c000000) $display("FAIL two_pc0 got %h want 1c000000", out_pc0); else passed++;
    total++; if (out_ir0 !== 32'hAAAA) $display("FAIL two_ir0 got %h want aaaa", out_ir0); else passed++;
    total++; if (out_pc1 !== 32'h1c000004) $display("FAIL two_pc1 got %h want 1c000004", out_pc1); else passed++;
    total++; if (out_ir1 !== 32'hBBBB) $display("FAIL two_ir1 got %h want bbbb", out_ir1); else passed++;
    total++; if (count !== 5'd2) $display("FAIL two_count got %0d want 2", count); else passed++;
    out_pop = 2'd2; tick; idle;
    total++; if (count !== 5'd0) $display("FAIL two_drain got %0d want 0", count); else passed++;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_two = 1'b1;
      in_pc = 32'h100 + 32'(8 * i); in_ir = {32'(2 * i + 1), 32'(2 * i)};
      tick;
    end
    total++; if (count !== 5'd14) $display("FAIL fill14_count got %0d want 14", count); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL fill14_ready got %b want 1", in_ready); else passed++;
    in_pc = 32'h138; in_ir = {32'd15, 32'd14}; tick;
    total++; if (count !== 5'd16) $display("FAIL fill16_count got %0d want 16", count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill16_ready got %b want 0", in_ready); else passed++;
    in_two = 1'b0; in_pc = 32'h999; in_ir = {32'd0, 32'h77}; tick; tick;
    total++; if (count !== 5'd16) $display("FAIL full_ignore got %0d want 16", count); else passed++;
    out_pop = 2'd1; tick;
    total++; if (count !== 5'd15) $display("FAIL fill15_count got %0d want 15", count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill15_ready got %b want 0", in_ready); else passed++;
    idle;
    for (int k = 1; k < 16; k += 2) begin
      total++; if (out_ir0 !== 32'(k)) $display("FAIL drain_ir0 got %h want %h", out_ir0, k); else passed++;
      total++; if (out_pc0 !== 32'h100 + 32'(4 * k)) $display("FAIL drain_pc0 got %h want %h", out_pc0, 32'h100 + 32'(4 * k)); else passed++;
      if (k < 15) begin
        total++; if (out_ir1 !== 32'(k + 1)) $display("FAIL drain_ir1 got %h want %h", out_ir1, k + 1); else passed++;
      end else begin
        total++; if (out_valid1 !== 1'b0) $display("FAIL drain_last_valid1 got %b want 0", out_valid1); else passed++;
      end
      out_pop = 2'd2; tick;
    end
    idle;
    total++; if (count !== 5'd0) $display("FAIL drain_count got %0d want 0", count); else passed++;
    total++; if (out_valid0 !== 1'b0) $display("FAIL drain_valid0 got %b want 0", out_valid0); else passed++;
  endtask

  task automatic test_wrap;
    base = 32'h2000;
    in_valid = 1'b1; in_two = 1'b1; in_ir = {32'd1, 32'd0}; in_pc = base; tick;
    in_two = 1'b0; in_ir = {32'd0, 32'd2}; in_pc = base + 32'd8; tick;
    idle;
    seq = 3; head = 0;
    total++; if (count !== 5'd3) $display("FAIL wrap_start got %0d want 3", count); else passed++;
    for (int lap = 0; lap < 24; lap++) begin
      total++; if (out_ir0 !== 32'(head)) $display("FAIL wrap_ir0 got %h want %h", out_ir0, head); else passed++;
      total++; if (out_pc0 !== base + 32'(4 * head)) $display("FAIL wrap_pc0 got %h want %h", out_pc0, base + 32'(4 * head)); else passed++;
      total++; if (out_ir1 !== 32'(head + 1)) $display("FAIL wrap_ir1 got %h want %h", out_ir1, head + 1); else passed++;
      in_valid = 1'b1; in_two = 1'b1; in_ir = {32'(seq + 1), 32'(seq)};
      in_pc = base + 32'(4 * seq); out_pop = 2'd1; tick;
      seq += 2; head += 1; idle;
      total++; if (count !== 5'd4) $display("FAIL wrap_pushpop_count got %0d want 4", count); else passed++;
      total++; if (out_ir0 !== 32'(head)) $display("FAIL wrap_adv_ir0 got %h want %h", out_ir0, head); else passed++;
      out_pop = 2'd1; tick;
      head += 1; idle;
      total++; if (count !== 5'd3) $display("FAIL wrap_pop_count got %0d want 3", count); else passed++;
    end
  endtask

  task automatic test_overpop;
    out_pop = 2'd2; tick; idle; head += 2;
    total++; if (count !== 5'd1) $display("FAIL op_count1 got %0d want 1", count); else passed++;
    total++; if (out_ir0 !== 32'(head)) $display("FAIL op_ir0 got %h want %h", out_ir0, head); else passed++;
    out_pop = 2'd2; tick; idle;
    total++; if (count !== 5'd0) $display("FAIL op_clamp got %0d want 0", count); else passed++;
    total++; if ({out_valid0, out_ir0} !== 33'd0) $display("FAIL op_empty got %h want 0", {out_valid0, out_ir0}); else passed++;
    out_pop = 2'd3; tick; idle;
    total++; if (count !== 5'd0) $display("FAIL op_empty_pop3 got %0d want 0", count); else passed++;
    in_valid = 1'b1; in_two = 1'b0; in_ir = {32'hFFFF, 32'hDEAD}; in_pc = 32'h3000; tick; idle;
    total++; if (count !== 5'd1) $display("FAIL op_push_count got %0d want 1", count); else passed++;
    total++; if (out_ir0 !== 32'hDEAD) $display("FAIL op_push_ir0 got %h want dead", out_ir0); else passed++;
    total++; if (out_pc0 !== 32'h3000) $display("FAIL op_push_pc0 got %h want 3000", out_pc0); else passed++;
    total++; if (out_valid1 !== 1'b0) $display("FAIL op_push_valid1 got %b want 0", out_valid1); else passed++;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_two = 1'b1; in_ir = {32'(2 * i + 8'h12), 32'(2 * i + 8'h11)};
      in_pc = 32'h400 + 32'(8 * i); tick;
    end
    idle;
    total++; if (count !== 5'd9) $display("FAIL fl_pre got %0d want 9", count); else passed++;
    flush = 1'b1; in_valid = 1'b1; in_two = 1'b1; out_pop = 2'd1; tick; idle;
    total++; if (count !== 5'd0) $display("FAIL fl_count got %0d want 0", count); else passed++;
    total++; if (out_valid0 !== 1'b0) $display("FAIL fl_valid0 got %b want 0", out_valid0); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL fl_ready got %b want 1", in_ready); else passed++;
    in_valid = 1'b1; in_two = 1'b0; in_ir = {32'd0, 32'h55}; in_pc = 32'h500; tick; idle;
    total++; if (count !== 5'd1) $display("FAIL fl_push_count got %0d want 1", count); else passed++;
    total++; if (out_ir0 !== 32'h55) $display("FAIL fl_push_ir0 got %h want 55", out_ir0); else passed++;
  endtask

  task automatic test_stall;
    in_valid = 1'b1; in_two = 1'b1; in_ir = {32'h67, 32'h66}; in_pc = 32'h600; tick; idle;
    total++; if (count !== 5'd3) $display("FAIL st_pre got %0d want 3", count); else passed++;
    stall = 1'b1; in_valid = 1'b1; in_two = 1'b1; in_ir = {32'h99, 32'h98}; out_pop = 2'd2;
    for (int c = 0; c < 3; c++) begin
      tick;
      total++; if (count !== 5'd3) $display("FAIL st_count got %0d want 3", count); else passed++;
      total++; if ({out_ir0, out_pc0} !== {32'h55, 32'h500}) $display("FAIL st_head got %h want 5500000500", {out_ir0, out_pc0}); else passed++;
      total++; if ({out_ir1, out_pc1} !== {32'h66, 32'h600}) $display("FAIL st_second got %h want 6600000600", {out_ir1, out_pc1}); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL st_ready got %b want 1", in_ready); else passed++;
    end
    idle;
    out_pop = 2'd1; tick; idle;
    total++; if (count !== 5'd2) $display("FAIL st_after_count got %0d want 2", count); else passed++;
    total++; if (out_ir0 !== 32'h66) $display("FAIL st_after_ir0 got %h want 66", out_ir0); else passed++;
    total++; if ({out_ir1, out_pc1} !== {32'h67, 32'h604}) $display("FAIL st_after_second got %h want 6700000604", {out_ir1, out_pc1}); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rstn   = 1'b0;
    in_pc  = '0;
    in_ir  = '0;
    idle;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset;
    test_two_push;
    test_fill;
    test_wrap;
    test_overpop;
    test_flush;
    test_stall;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised circular instruction queue between the instruction cache and the decode stage. It accepts up to two instructions per cycle from fetch, with the second PC derived as first PC + 4. It presents the two oldest entries to decode, which pops 0, 1 or 2 per cycle. It supersedes the fixed 16-entry shift-register buffer with a pointer-based ring, valid/ready handshakes, occupancy reporting and a defined pop-clamp rule.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 4
- IW, 32, instruction width
- PW, 32, PC width
- CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear; highest priority after reset
- stall  in  1  freezes all state; flush still acts
- in_valid  in  1  fetch offers a packet
- in_two  in  1  packet holds two instructions; 0 means only in_ir[IW-1:0] is valid
- in_pc  in  PW  PC of in_ir[IW-1:0]
- in_ir  in  2*IW  [IW-1:0] is the older instruction, [2*IW-1:IW] is the younger one
- in_ready  out  1  queue can take a full two-instruction packet
- out_valid0 / out_valid1  out  1 each  head entry / second entry present
- out_ir0, out_pc0  out  IW, PW  oldest entry
- out_ir1, out_pc1  out  IW, PW  second-oldest entry
- out_pop  in  2  entries consumed by decode this cycle (0..2; 3 is treated as 2)
- count  out  CW  current occupancy

## Operation
- Storage: ring of DEPTH {ir, pc} entries. Head pointer rd_ptr and tail pointer wr_ptr, each log2(DEPTH) bits, wrap modulo DEPTH. Separate counter `count` tracks occupancy.
- in_ready = (DEPTH − count) ≥ 2. It is combinational from registered count only and does not depend on out_pop.
- Push occurs when in_valid & in_ready & !stall & !flush:
  - Writes {in_ir[IW-1:0], in_pc} at wr_ptr.
  - If in_two, also writes {in_ir[2IW-1:IW], in_pc+4} at wr_ptr+1, with the addition truncated to PW bits.
  - wr_ptr advances by 1 + in_two.
- Pop: eff_pop = min(out_pop saturated to 2, count). rd_ptr advances by eff_pop when !stall & !flush. Over-pop is clamped and is never an underflow.
- count_next = count + push_n − eff_pop, where push_n ∈ {0,1,2}. Push and pop in the same cycle are both honoured.
- Outputs:
  - out_valid0 = count ≥ 1; out_valid1 = count ≥ 2.
  - out_ir0/out_pc0 read entry rd_ptr; out_ir1/out_pc1 read entry rd_ptr+1 (mod DEPTH).
  - Each ir/pc pair is forced to 0 when its valid is low.
- Flush (synchronous): rd_ptr = wr_ptr = count = 0 at the next edge. Push and pop in the same cycle are discarded. Storage contents need not be cleared.
- Stall without flush: no pointer, counter or storage change. Outputs hold, and in_ready still reflects count.
- Reset (asynchronous, rstn low): pointers 0, count 0, out_valid0/1 = 0, all out_ir/out_pc = 0, in_ready = 1. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Push-to-visible latency is 1 cycle. An entry written at edge N appears on outputs after edge N. There is no same-cycle bypass, so with an empty queue and a push, out_valid0 stays 0 in that cycle.
- Pop takes effect at the edge. Outputs show the new head in the following cycle.
- Full boundary:
  - count = DEPTH−1 or DEPTH → in_ready = 0, even for a single-instruction packet.
  - count = DEPTH−2 → in_ready = 1.
  - An offered packet with in_ready = 0 is not written; fetch must hold it.
- Empty boundary: count = 0 → both out_valid low; any out_pop is clamped to 0.
- Wrap: with wr_ptr = DEPTH−1 and in_two, the second entry lands at index 0 and wr_ptr becomes 1.
- count never exceeds DEPTH and never goes below 0.

## Test plan
- Reset: rstn low mid-stream with count = 5 → count = 0, out_valid0/1 = 0, outputs 0, in_ready = 1, all without a clock edge.
- Two-wide push into an empty queue, in_pc = 0x1c000000, in_ir = {0xBBBB, 0xAAAA}:
  - Next cycle: out_pc0 = 0x1c000000, out_ir0 = 0xAAAA, out_pc1 = 0x1c000004, out_ir1 = 0xBBBB, count = 2.
- Fill DEPTH=16 with 7 two-wide pushes:
  - count = 14, in_ready = 1.
  - Eighth push → count = 16, in_ready = 0.
  - Further in_valid is ignored until a pop.
- Simultaneous push of 2 and out_pop = 1 at count = 3 → count = 4; head advances by one and FIFO order is preserved across wrap (run ≥ 3 laps).
- Over-pop at count = 1 with out_pop = 2 → count = 0 with no underflow; the next push of one instruction gives count = 1 with the correct data.
- Flush together with push and pop at count = 9 → count = 0, out_valid0 = 0. Stall held 3 cycles with push and pop requests → count, outputs and pointers unchanged.
